// File: rtl/dvs_ravens_pkg.sv
// Shared constants and types for the RAVENS packet receiver.
// Packet layout, opcode encodings and receiver FSM states.
package dvs_ravens_pkg;

    localparam int RAVENS_PKT_BITS = 32;
    localparam int NEURON_ID_BITS  = 8;

    localparam logic [2:0] OP_SPIKE = 3'b000;
    localparam logic [2:0] OP_RUN   = 3'b001;
    localparam logic [2:0] OP_CLEAR = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_DONE
    } rx_state_e;

endpackage

// File: rtl/ravens_spike_fifo.sv
// Spike buffer: synchronous FIFO with registered full flag.
// Ports: clk, rst (sync, active-high), push_i/push_data_i,
// pop_i/pop_data_o, empty_o, full_o. DEPTH must be a power of two >= 2.
module ravens_spike_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             full_q, full_d;
    logic             do_push, do_pop;

    assign do_push = push_i & ~full_q;
    assign do_pop  = pop_i & (cnt_q != '0);

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) wr_d = wr_q + 1'b1;
        if (do_pop)  rd_d = rd_q + 1'b1;
        if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
        else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
        full_d = (cnt_d == CW'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            full_q <= full_d;
        end
    end

    // Storage needs no reset; the read port is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= push_data_i;
    end

    assign empty_o    = (cnt_q == '0);
    assign full_o     = full_q;
    assign pop_data_o = empty_o ? '0 : mem_q[rd_q];

endmodule

// File: rtl/ravens_pkt_receiver.sv
// RAVENS packet receiver: decodes SPIKE/RUN/CLEAR packets, tracks
// the sim timestep and buffers tagged spikes for downstream.
// Ports: pkt_valid/ravens_pkt/pkt_rdy in, out_valid/out_ready/
// out_neuron_id/out_timestep out, sim_time_done pulse, sticky errors.
module ravens_pkt_receiver
    import dvs_ravens_pkg::*;
#(
    parameter int SIM_TIME   = 15,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pkt_valid,
    input  logic [RAVENS_PKT_BITS-1:0]   ravens_pkt,
    output logic                         pkt_rdy,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NEURON_ID_BITS-1:0]    out_neuron_id,
    output logic [$clog2(SIM_TIME+1)-1:0] out_timestep,
    output logic                         sim_time_done,
    output logic                         err_illegal,
    output logic                         err_dropped
);

    localparam int TSW = $clog2(SIM_TIME + 1);
    localparam int FW  = NEURON_ID_BITS + TSW;

    rx_state_e       state_q, state_d;
    logic [TSW-1:0]  ts_q, ts_d;
    logic            done_q, done_d;
    logic            ill_q, ill_d;
    logic            drop_q, drop_d;

    logic            accept;
    logic            push;
    logic            fifo_full;
    logic            fifo_empty;
    logic [2:0]      opcode;
    logic [28:0]     run_cnt;
    logic [28:0]     run_eff;
    logic [29:0]     run_sum;
    logic            run_sat;
    logic [TSW-1:0]  run_ts;
    logic [FW-1:0]   fifo_rd;

    assign opcode  = ravens_pkt[31:29];
    assign run_cnt = ravens_pkt[28:0];
    assign pkt_rdy = ~fifo_full;
    assign accept  = pkt_valid & pkt_rdy;

    // One extra bit keeps timestep + 29-bit count from wrapping.
    assign run_eff = (run_cnt == '0) ? 29'd1 : run_cnt;
    assign run_sum = {{(30-TSW){1'b0}}, ts_q} + {1'b0, run_eff};
    assign run_sat = (run_sum >= 30'(SIM_TIME));
    assign run_ts  = run_sat ? TSW'(SIM_TIME) : run_sum[TSW-1:0];

    always_comb begin
        state_d = state_q;
        ts_d    = ts_q;
        done_d  = 1'b0;
        ill_d   = ill_q;
        drop_d  = drop_q;
        push    = 1'b0;
        if (accept) begin
            case (opcode)
                OP_CLEAR: begin
                    ts_d    = '0;
                    state_d = ST_ACTIVE;
                end
                OP_SPIKE: begin
                    if (state_q == ST_ACTIVE) push   = 1'b1;
                    else                      drop_d = 1'b1;
                end
                OP_RUN: begin
                    if (state_q == ST_ACTIVE) begin
                        ts_d = run_ts;
                        if (run_sat) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: ill_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ts_q    <= '0;
            done_q  <= 1'b0;
            ill_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ts_q    <= ts_d;
            done_q  <= done_d;
            ill_q   <= ill_d;
            drop_q  <= drop_d;
        end
    end

    ravens_spike_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i ({ravens_pkt[NEURON_ID_BITS-1:0], ts_q}),
        .pop_i       (out_ready),
        .pop_data_o  (fifo_rd),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

    assign out_valid     = ~fifo_empty;
    assign out_neuron_id = fifo_rd[FW-1:TSW];
    assign out_timestep  = fifo_rd[TSW-1:0];
    assign sim_time_done = done_q;
    assign err_illegal   = ill_q;
    assign err_dropped   = drop_q;

endmodule

// File: tb/tb_ravens_pkt_receiver.sv
// Directed testbench for ravens_pkt_receiver.
// Inputs change and outputs are sampled on the falling edge.
module tb_ravens_pkt_receiver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pkt_valid = 1'b0;
    logic [31:0] ravens_pkt = '0;
    logic        pkt_rdy;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_neuron_id;
    logic [3:0]  out_timestep;
    logic        sim_time_done;
    logic        err_illegal;
    logic        err_dropped;

    int cmp = 0;
    int bad = 0;

    always #5 clk = ~clk;

    ravens_pkt_receiver #(.SIM_TIME(15), .FIFO_DEPTH(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .pkt_valid     (pkt_valid),
        .ravens_pkt    (ravens_pkt),
        .pkt_rdy       (pkt_rdy),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_neuron_id (out_neuron_id),
        .out_timestep  (out_timestep),
        .sim_time_done (sim_time_done),
        .err_illegal   (err_illegal),
        .err_dropped   (err_dropped)
    );

    function automatic logic [31:0] p_spike(input logic [7:0] id);
        return {3'b000, 21'd0, id};
    endfunction
    function automatic logic [31:0] p_run(input logic [28:0] n);
        return {3'b001, n};
    endfunction
    localparam logic [31:0] P_CLEAR = 32'h4000_0000;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [31:0] p);
        pkt_valid  = 1'b1;
        ravens_pkt = p;
        tick();
        pkt_valid  = 1'b0;
        ravens_pkt = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pkt_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        out_ready = 1'b0;
        do_reset();
        cmp++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
        cmp++; if (out_neuron_id !== 8'd0) begin bad++; $display("FAIL rst_id got=%0d exp=0", out_neuron_id); end
        cmp++; if (out_timestep !== 4'd0) begin bad++; $display("FAIL rst_ts got=%0d exp=0", out_timestep); end
        cmp++; if ({sim_time_done, err_illegal, err_dropped} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b exp=000", {sim_time_done, err_illegal, err_dropped}); end
        cmp++; if (pkt_rdy !== 1'b1) begin bad++; $display("FAIL rst_rdy got=%b exp=1", pkt_rdy); end
    endtask

    task automatic test_basic();
        do_reset();
        out_ready = 1'b1;
        send(P_CLEAR);
        send(p_spike(8'd5));
        cmp++; if ({out_valid, out_neuron_id, out_timestep} !== {1'b1, 8'd5, 4'd0}) begin bad++; $display("FAIL s1_first got=%b/%0d/%0d exp=1/5/0", out_valid, out_neuron_id, out_timestep); end
        send(p_run(29'd3));
        cmp++; if (out_valid !== 1'b0) begin bad++; $display("FAIL s1_popped got=%b exp=0", out_valid); end
        send(p_spike(8'd9));
        cmp++; if ({out_valid, out_neuron_id, out_timestep} !== {1'b1, 8'd9, 4'd3}) begin bad++; $display("FAIL s1_second got=%b/%0d/%0d exp=1/9/3", out_valid, out_neuron_id, out_timestep); end
        cmp++; if (sim_time_done !== 1'b0) begin bad++; $display("FAIL s1_done got=%b exp=0", sim_time_done); end
        tick();
    endtask

    task automatic test_saturate();
        do_reset();
        out_ready = 1'b1;
        send(P_CLEAR);
        send(p_run(29'd10));
        cmp++; if (sim_time_done !== 1'b0) begin bad++; $display("FAIL s2_early_done got=%b exp=0", sim_time_done); end
        send(p_run(29'd10));
        cmp++; if (sim_time_done !== 1'b1) begin bad++; $display("FAIL s2_pulse got=%b exp=1", sim_time_done); end
        tick();
        cmp++; if (sim_time_done !== 1'b0) begin bad++; $display("FAIL s2_pulse_len got=%b exp=0", sim_time_done); end
        send(p_spike(8'd2));
        cmp++; if ({err_dropped, out_valid} !== 2'b10) begin bad++; $display("FAIL s2_dropped got=%b exp=10", {err_dropped, out_valid}); end
        do_reset();
        send(P_CLEAR);
        send(p_run(29'd14));
        send(p_spike(8'd1));
        cmp++; if ({out_neuron_id, out_timestep, sim_time_done} !== {8'd1, 4'd14, 1'b0}) begin bad++; $display("FAIL s2_ts14 got=%0d/%0d/%b exp=1/14/0", out_neuron_id, out_timestep, sim_time_done); end
        send(p_run(29'h1FFF_FFFF));
        cmp++; if (sim_time_done !== 1'b1) begin bad++; $display("FAIL s2_bigrun got=%b exp=1", sim_time_done); end
    endtask

    task automatic test_full();
        do_reset();
        out_ready = 1'b0;
        send(P_CLEAR);
        for (int i = 1; i <= 8; i++) begin
            cmp++; if (pkt_rdy !== 1'b1) begin bad++; $display("FAIL s3_rdy_%0d got=%b exp=1", i, pkt_rdy); end
            send(p_spike(8'(i)));
        end
        cmp++; if (pkt_rdy !== 1'b0) begin bad++; $display("FAIL s3_full got=%b exp=0", pkt_rdy); end
        pkt_valid  = 1'b1;
        ravens_pkt = p_spike(8'd9);
        tick();
        cmp++; if ({pkt_rdy, out_neuron_id} !== {1'b0, 8'd1}) begin bad++; $display("FAIL s3_hold got=%b/%0d exp=0/1", pkt_rdy, out_neuron_id); end
        out_ready = 1'b1;
        tick();
        cmp++; if ({pkt_rdy, out_valid, out_neuron_id} !== {1'b1, 1'b1, 8'd2}) begin bad++; $display("FAIL s3_after_pop got=%b/%b/%0d exp=1/1/2", pkt_rdy, out_valid, out_neuron_id); end
        tick();
        pkt_valid = 1'b0;
        for (int i = 3; i <= 9; i++) begin
            cmp++; if ({out_valid, out_neuron_id, out_timestep} !== {1'b1, 8'(i), 4'd0}) begin bad++; $display("FAIL s3_drain_%0d got=%b/%0d/%0d exp=1/%0d/0", i, out_valid, out_neuron_id, out_timestep, i); end
            tick();
        end
        cmp++; if (out_valid !== 1'b0) begin bad++; $display("FAIL s3_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_illegal();
        do_reset();
        out_ready = 1'b1;
        send(P_CLEAR);
        send(p_run(29'd2));
        send(32'hA000_0000);
        cmp++; if ({err_illegal, err_dropped} !== 2'b10) begin bad++; $display("FAIL s4_flag got=%b exp=10", {err_illegal, err_dropped}); end
        send(p_spike(8'd7));
        cmp++; if ({out_valid, out_neuron_id, out_timestep} !== {1'b1, 8'd7, 4'd2}) begin bad++; $display("FAIL s4_tag got=%b/%0d/%0d exp=1/7/2", out_valid, out_neuron_id, out_timestep); end
        tick();
        cmp++; if (err_illegal !== 1'b1) begin bad++; $display("FAIL s4_sticky got=%b exp=1", err_illegal); end
    endtask

    task automatic test_run_zero();
        do_reset();
        out_ready = 1'b1;
        send(P_CLEAR);
        send(p_run(29'd4));
        send(p_run(29'd0));
        send(p_spike(8'd3));
        cmp++; if ({out_neuron_id, out_timestep} !== {8'd3, 4'd5}) begin bad++; $display("FAIL s5_run0 got=%0d/%0d exp=3/5", out_neuron_id, out_timestep); end
        send(p_run(29'd10));
        cmp++; if (sim_time_done !== 1'b1) begin bad++; $display("FAIL s5_done got=%b exp=1", sim_time_done); end
        send(P_CLEAR);
        cmp++; if (sim_time_done !== 1'b0) begin bad++; $display("FAIL s5_clear_done got=%b exp=0", sim_time_done); end
        send(p_spike(8'd4));
        cmp++; if ({out_valid, out_neuron_id, out_timestep, err_dropped} !== {1'b1, 8'd4, 4'd0, 1'b0}) begin bad++; $display("FAIL s5_reactive got=%b/%0d/%0d/%b exp=1/4/0/0", out_valid, out_neuron_id, out_timestep, err_dropped); end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b0;
        send(P_CLEAR);
        send(p_spike(8'd1));
        send(p_spike(8'd2));
        send(p_spike(8'd3));
        send(32'hE000_0000);
        cmp++; if ({out_valid, err_illegal} !== 2'b11) begin bad++; $display("FAIL s6_pre got=%b exp=11", {out_valid, err_illegal}); end
        rst        = 1'b1;
        pkt_valid  = 1'b1;
        ravens_pkt = p_spike(8'd6);
        tick();
        rst       = 1'b0;
        pkt_valid = 1'b0;
        cmp++; if ({out_valid, out_neuron_id, out_timestep} !== {1'b0, 8'd0, 4'd0}) begin bad++; $display("FAIL s6_out got=%b/%0d/%0d exp=0/0/0", out_valid, out_neuron_id, out_timestep); end
        cmp++; if ({sim_time_done, err_illegal, err_dropped, pkt_rdy} !== 4'b0001) begin bad++; $display("FAIL s6_flags got=%b exp=0001", {sim_time_done, err_illegal, err_dropped, pkt_rdy}); end
        send(p_spike(8'd8));
        cmp++; if ({err_dropped, out_valid} !== 2'b10) begin bad++; $display("FAIL s6_idle got=%b exp=10", {err_dropped, out_valid}); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_saturate();
        test_full();
        test_illegal();
        test_run_zero();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end

endmodule
